// File: rtl/spi_master.sv
// Single-byte SPI master, mode 0 (CPOL=0, CPHA=0), MSB first, with a valid/ready
// byte handshake and software-controlled chip select. All logic runs on i_clk.
module spi_master #(
  parameter int unsigned CLKS_PER_HALF_BIT = 2
) (
  input  logic       i_clk,
  input  logic       i_sys_rst,
  input  logic [7:0] i_tx_byte,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_valid,
  input  logic       i_cs_en,
  output logic       o_busy,
  output logic       o_sck,
  output logic       o_mosi,
  input  logic       i_miso,
  output logic       o_cs_n
);

  typedef enum logic {IDLE, XFER} state_t;

  localparam logic [7:0] HALF_TC = 8'(CLKS_PER_HALF_BIT - 1);

  state_t     r_state;
  logic [7:0] r_half_cnt;
  logic [3:0] r_edge_cnt;
  logic [7:0] r_tx_shift;
  logic [7:0] r_rx_shift;
  logic       r_sck;
  logic       r_mosi;
  logic       r_cs_n;
  logic       r_tx_ready;
  logic [7:0] r_rx_byte;
  logic       r_rx_valid;

  state_t     w_state;
  logic [7:0] w_half_cnt;
  logic [3:0] w_edge_cnt;
  logic [7:0] w_tx_shift;
  logic [7:0] w_rx_shift;
  logic       w_sck;
  logic       w_mosi;
  logic       w_cs_n;
  logic       w_tx_ready;
  logic [7:0] w_rx_byte;
  logic       w_rx_valid;
  logic       w_accept;
  logic       w_half_tc;

  assign w_accept  = i_tx_valid & r_tx_ready;
  assign w_half_tc = (r_half_cnt == HALF_TC);

  always_comb begin
    // NOTE: every next-value is defaulted before the case so no latch can be inferred.
    w_state    = r_state;
    w_half_cnt = r_half_cnt;
    w_edge_cnt = r_edge_cnt;
    w_tx_shift = r_tx_shift;
    w_rx_shift = r_rx_shift;
    w_sck      = r_sck;
    w_mosi     = r_mosi;
    w_cs_n     = r_cs_n;
    w_tx_ready = r_tx_ready;
    w_rx_byte  = r_rx_byte;
    w_rx_valid = 1'b0;

    case (r_state)
      IDLE: begin
        w_sck      = 1'b0;
        w_mosi     = 1'b1;
        w_tx_ready = 1'b1;
        w_cs_n     = ~i_cs_en;
        if (w_accept) begin
          w_state    = XFER;
          w_tx_shift = i_tx_byte;
          w_half_cnt = 8'd0;
          w_edge_cnt = 4'd0;
          w_mosi     = i_tx_byte[7];
          w_tx_ready = 1'b0;
        end
      end

      XFER: begin
        if (!w_half_tc) begin
          w_half_cnt = r_half_cnt + 8'd1;
        end else begin
          w_half_cnt = 8'd0;
          w_sck      = ~r_sck;
          w_edge_cnt = r_edge_cnt + 4'd1;
          if (!r_sck) begin
            // Rising SCK: the slave has had a full low half-period of setup.
            w_rx_shift = {r_rx_shift[6:0], i_miso};
          end else if (r_edge_cnt == 4'd15) begin
            // Falling edge after the 8th pulse ends the byte.
            w_state    = IDLE;
            w_rx_byte  = r_rx_shift;
            w_rx_valid = 1'b1;
            w_tx_ready = 1'b1;
            w_mosi     = 1'b1;
          end else begin
            w_tx_shift = r_tx_shift << 1;
            w_mosi     = r_tx_shift[6];
          end
        end
      end

      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (i_sys_rst) begin
      r_state    <= IDLE;
      r_half_cnt <= 8'd0;
      r_edge_cnt <= 4'd0;
      r_tx_shift <= 8'd0;
      r_rx_shift <= 8'd0;
      r_sck      <= 1'b0;
      r_mosi     <= 1'b1;
      r_cs_n     <= 1'b1;
      r_tx_ready <= 1'b0;
      r_rx_byte  <= 8'h00;
      r_rx_valid <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_half_cnt <= w_half_cnt;
      r_edge_cnt <= w_edge_cnt;
      r_tx_shift <= w_tx_shift;
      r_rx_shift <= w_rx_shift;
      r_sck      <= w_sck;
      r_mosi     <= w_mosi;
      r_cs_n     <= w_cs_n;
      r_tx_ready <= w_tx_ready;
      r_rx_byte  <= w_rx_byte;
      r_rx_valid <= w_rx_valid;
    end
  end

  assign o_tx_ready = r_tx_ready;
  assign o_rx_byte  = r_rx_byte;
  assign o_rx_valid = r_rx_valid;
  assign o_busy     = (r_state == XFER);
  assign o_sck      = r_sck;
  assign o_mosi     = r_mosi;
  assign o_cs_n     = r_cs_n;

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Single-byte SPI master, mode 0 (CPOL=0, CPHA=0), MSB first.
- Drives SCK, MOSI and CS_n toward an external SPI slave (SD card on the ICEstick PMOD).
- Shifts MISO back in and presents each completed byte to the system logic via a valid/ready byte handshake, all in the i_clk domain.
- Chip select is software-controlled, so multi-byte commands keep CS asserted and SD-card init clocks can run with CS high.

Parameters:
- CLKS_PER_HALF_BIT, 2: i_clk cycles per SCK half-period (H). Legal range is 2..255. SCK frequency = f(i_clk)/(2*H).

Ports:
- i_clk  input  1  system clock; every register in the block uses its rising edge.
- i_sys_rst  input  1  synchronous, active-high reset.
- i_tx_byte  input  8  byte to transmit; sampled only at accept.
- i_tx_valid  input  1  request to send i_tx_byte.
- o_tx_ready  output  1  block idle and able to accept a byte.
- o_rx_byte  output  8  last byte received on MISO; holds until the next completion.
- o_rx_valid  output  1  one-cycle pulse when o_rx_byte updates.
- i_cs_en  input  1  1 = assert chip select (o_cs_n low).
- o_busy  output  1  byte transfer in progress.
- o_sck  output  1  SPI clock, idles low.
- o_mosi  output  1  master out; idles high.
- i_miso  input  1  master in.
- o_cs_n  output  1  chip select, active low.

Behaviour:
- Reset: one clock; reset is synchronous and active-high. While i_sys_rst=1, outputs are held as follows:
  - o_sck=0, o_mosi=1, o_cs_n=1
  - o_tx_ready=0, o_busy=0
  - o_rx_valid=0, o_rx_byte=8'h00
  - internal state=IDLE, counters cleared
- Reset has priority over everything and aborts a transfer mid-byte:
  - no o_rx_valid is produced
  - the partial byte is discarded
  - o_tx_ready=1 on the first cycle after reset releases
- States: IDLE, XFER.
- IDLE:
  - o_tx_ready=1, o_busy=0, o_sck=0, o_mosi=1.
  - o_cs_n <= ~i_cs_en every IDLE cycle, including the accept cycle.
  - Accept = i_tx_valid & o_tx_ready at a clock edge. On accept:
    - latch i_tx_byte into the shift register
    - clear the bit and half-period counters
    - go to XFER
- XFER, relative to the cycle after the accept edge (call it cycle 1):
  - Cycle 1 onward: o_busy=1, o_tx_ready=0, o_mosi=bit7, o_sck=0.
  - Half-period counter runs 0..H-1. At terminal count o_sck toggles.
  - Rising edge of o_sck (low->high): i_miso is captured into the LSB of the rx shift register on that same i_clk edge. No synchronizer; the slave has H cycles of setup.
  - Falling edge of o_sck (high->low) after bits 7..1: o_mosi advances to the next lower bit.
  - After the 8th rising edge, o_sck stays high for H cycles, then falls. On that same edge:
    - o_rx_byte <= rx shift register
    - o_rx_valid=1 for exactly one cycle
    - state returns to IDLE, so o_tx_ready=1 and o_mosi=1 in that cycle
  - Result: 8 SCK pulses, each high exactly H cycles and low exactly H cycles.
  - Accept-to-o_rx_valid latency = 16*H cycles (o_rx_valid high in cycle 16*H).
- Back-to-back:
  - i_tx_valid held high during the o_rx_valid cycle is accepted on that edge.
  - Byte period = 16*H+1 cycles.
  - SCK low gap between bytes = H+1 cycles.
- o_cs_n is frozen during XFER; i_cs_en changes are ignored until the next IDLE cycle. CS is never changed while o_sck=1.
- i_tx_valid and i_tx_byte during XFER are ignored (not queued).
- Transfers with i_cs_en=0 are legal: o_cs_n stays high while SCK toggles (SD 74-clock init).
- o_rx_byte is unchanged between o_rx_valid pulses.

Test Plan:
- Reset, then H=2, i_cs_en=1, send 8'hA5 with i_miso looped to o_mosi:
  - o_cs_n=0 from the accept cycle+1
  - exactly 8 SCK pulses, each 2 high / 2 low
  - MOSI sampled on rising edges = 1,0,1,0,0,1,0,1
  - o_rx_valid at cycle 32 after accept, o_rx_byte=8'hA5
- Mode-0 slave model returning 8'h3C while master sends 8'hFF -> o_rx_byte=8'h3C. Repeat with H=5 -> latency 80 cycles.
- Three bytes 8'h40,8'h00,8'h95 with i_tx_valid held high and i_cs_en=1:
  - each accepted on the previous o_rx_valid cycle
  - byte period 33 cycles (H=2)
  - o_cs_n low throughout, SCK gap 3 cycles
- i_cs_en=0, send 10 x 8'hFF -> 80 SCK pulses, o_cs_n=1 and o_mosi=1 throughout.
- i_cs_en dropped to 0 mid-byte -> o_cs_n stays 0 until the o_rx_valid cycle, goes 1 the next cycle.
- Assert i_sys_rst for 1 cycle at the 4th SCK high phase:
  - next cycle o_sck=0, o_cs_n=1, o_mosi=1
  - no o_rx_valid, o_rx_byte=8'h00
  - o_tx_ready=1 the cycle after reset releases
  - a fresh 8'h5A transfer then completes correctly.
